bsg_manycore_link_to_axil_tx_gen: RTL

- Parametrised host-side transmit/receive bridge between a narrow AXI-Lite data stream and wide manycore host-FIFO packets.
- Buffers request beats and assembles them into packets.
- Throttles remote-load packets against a runtime-programmable read-credit limit.
- Serialises response packets back into beats.
- Exposes vacancy, occupancy and outstanding-read counters, plus a sticky error flag for unsolicited responses, for host polling.

---
 rtl/bsg_manycore_link_to_axil_tx_gen.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/bsg_manycore_link_to_axil_tx_gen.sv
// ---------------------------------------------------------------------------
// bsg_manycore_link_to_axil_tx_gen
//
// Host-side bridge between a narrow AXI-Lite beat stream and wide manycore
// host-FIFO packets.
//   * Request path : beats are buffered, assembled LSB-first into packets and
//                    offered on fifo_req_*. Remote loads are held back while
//                    the outstanding-read count has reached the runtime
//                    credit limit (clamped to rsp_els_p).
//   * Response path: packets from fifo_rsp_* are serialised LSB-first into a
//                    beat buffer drained through axil_rsp_*.
//   * Status       : free request beats, waiting response beats, outstanding
//                    reads, and a sticky flag for responses that arrive while
//                    no read is outstanding.
//
// Ports
//   clk_i, reset_i                      clock, asynchronous active-high reset
//   axil_req_i/_v_i/_ready_o            request beat in
//   axil_rsp_o/_v_o/_ready_i            response beat out
//   fifo_req_o/_v_o/_ready_i            assembled request packet out
//   fifo_rsp_i/_v_i/_ready_o            response packet in
//   read_credit_limit_i                 runtime cap on outstanding reads
//   req_vacancy_o                       free request-buffer beats
//   rsp_occupancy_o                     beats waiting in the response buffer
//   outstanding_reads_o                 reads sent and not yet answered
//   unsolicited_err_o, err_clear_i      sticky unsolicited-response flag
// ---------------------------------------------------------------------------
module bsg_manycore_link_to_axil_tx_gen #(
    parameter int axil_data_width_p = 32,
    parameter int fifo_width_p      = 128,
    parameter int req_els_p         = 4,
    parameter int rsp_els_p         = 4,
    parameter int op_lsb_p          = 104,
    parameter int op_width_p        = 8,
    parameter int load_op_p         = 0,
    localparam int ratio_lp         = fifo_width_p / axil_data_width_p,
    localparam int credit_w_lp      = $clog2(rsp_els_p + 1),
    localparam int req_depth_lp     = ratio_lp * req_els_p,
    localparam int rsp_depth_lp     = ratio_lp * rsp_els_p,
    localparam int req_cnt_w_lp     = $clog2(req_depth_lp + 1),
    localparam int rsp_cnt_w_lp     = $clog2(rsp_depth_lp + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [axil_data_width_p-1:0] axil_req_i,
    input  logic                         axil_req_v_i,
    output logic                         axil_req_ready_o,
    output logic [axil_data_width_p-1:0] axil_rsp_o,
    output logic                         axil_rsp_v_o,
    input  logic                         axil_rsp_ready_i,
    output logic [fifo_width_p-1:0]      fifo_req_o,
    output logic                         fifo_req_v_o,
    input  logic                         fifo_req_ready_i,
    input  logic [fifo_width_p-1:0]      fifo_rsp_i,
    input  logic                         fifo_rsp_v_i,
    output logic                         fifo_rsp_ready_o,
    input  logic [credit_w_lp-1:0]       read_credit_limit_i,
    output logic [req_cnt_w_lp-1:0]      req_vacancy_o,
    output logic [rsp_cnt_w_lp-1:0]      rsp_occupancy_o,
    output logic [credit_w_lp-1:0]       outstanding_reads_o,
    output logic                         unsolicited_err_o,
    input  logic                         err_clear_i
);

    if ((fifo_width_p % axil_data_width_p) != 0 || ratio_lp < 1) begin : g_width_check
        $fatal(1, "fifo_width_p must be a non-zero multiple of axil_data_width_p");
    end

    localparam int beat_w_lp    = (ratio_lp > 1) ? $clog2(ratio_lp) : 1;
    localparam int req_ptr_w_lp = (req_depth_lp > 1) ? $clog2(req_depth_lp) : 1;
    localparam int rsp_ptr_w_lp = (rsp_depth_lp > 1) ? $clog2(rsp_depth_lp) : 1;

    localparam logic [beat_w_lp-1:0]    beat_last_lp    = beat_w_lp'(ratio_lp - 1);
    localparam logic [req_ptr_w_lp-1:0] req_ptr_last_lp = req_ptr_w_lp'(req_depth_lp - 1);
    localparam logic [rsp_ptr_w_lp-1:0] rsp_ptr_last_lp = rsp_ptr_w_lp'(rsp_depth_lp - 1);
    localparam logic [req_cnt_w_lp-1:0] req_full_lp     = req_cnt_w_lp'(req_depth_lp);
    localparam logic [rsp_cnt_w_lp-1:0] rsp_full_lp     = rsp_cnt_w_lp'(rsp_depth_lp);
    localparam logic [credit_w_lp-1:0]  credit_max_lp   = credit_w_lp'(rsp_els_p);
    localparam logic [op_width_p-1:0]   load_op_lp      = op_width_p'(load_op_p);

    typedef enum logic {FILL, SEND}  asm_state_e;
    typedef enum logic {IDLE, SHIFT} ser_state_e;

    asm_state_e asm_state, asm_next;
    ser_state_e ser_state, ser_next;

    // ---------------- request beat buffer ----------------
    logic [axil_data_width_p-1:0] req_mem [req_depth_lp];
    logic [req_ptr_w_lp-1:0]      req_wr_ptr, req_rd_ptr;
    logic [req_cnt_w_lp-1:0]      req_count;
    logic                         req_push, req_pop;

    assign axil_req_ready_o = (req_count != req_full_lp);
    assign req_push         = axil_req_v_i & axil_req_ready_o;
    assign req_pop          = (asm_state == FILL) & (req_count != '0);
    assign req_vacancy_o    = req_full_lp - req_count;

    // NOTE: storage arrays carry no reset; only the pointers and counts that
    // say which entries are valid need one, and that keeps the array a plain RAM.
    always_ff @(posedge clk_i) begin
        if (req_push) req_mem[req_wr_ptr] <= axil_req_i;
    end

    // NOTE: every clocked block updates state with non-blocking assignments so
    // all registers sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_count  <= '0;
        end else begin
            if (req_push) req_wr_ptr <= (req_wr_ptr == req_ptr_last_lp) ? '0 : req_wr_ptr + 1'b1;
            if (req_pop)  req_rd_ptr <= (req_rd_ptr == req_ptr_last_lp) ? '0 : req_rd_ptr + 1'b1;
            if (req_push & ~req_pop)      req_count <= req_count + 1'b1;
            else if (~req_push & req_pop) req_count <= req_count - 1'b1;
        end
    end

    // ---------------- request assembler + read throttle ----------------
    logic [beat_w_lp-1:0]    asm_cnt;
    logic [fifo_width_p-1:0] pkt_r;
    logic [credit_w_lp-1:0]  outstanding_r, limit_eff, outstanding_eff;
    logic                    is_read, pause, req_hs, read_hs, rsp_hs, credit_ret, err_r;

    assign fifo_req_o = pkt_r;
    assign is_read    = (pkt_r[op_lsb_p +: op_width_p] == load_op_lp);
    assign limit_eff  = (read_credit_limit_i > credit_max_lp) ? credit_max_lp : read_credit_limit_i;

    // A response accepted this cycle returns its credit immediately, so a
    // throttled load can go out in the same cycle the answer arrives.
    assign credit_ret      = rsp_hs & (outstanding_r != '0);
    assign outstanding_eff = outstanding_r - credit_w_lp'(credit_ret);
    assign pause           = is_read & (outstanding_eff >= limit_eff);

    assign fifo_req_v_o = (asm_state == SEND) & ~pause;
    assign req_hs       = fifo_req_v_o & fifo_req_ready_i;
    assign read_hs      = req_hs & is_read;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) asm_state <= FILL;
        else         asm_state <= asm_next;
    end

    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a signal unassigned and infers a latch.
    always_comb begin
        asm_next = asm_state;
        case (asm_state)
            FILL:    if (req_pop && asm_cnt == beat_last_lp) asm_next = SEND;
            SEND:    if (req_hs) asm_next = FILL;
            default: asm_next = FILL;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            asm_cnt <= '0;
            pkt_r   <= '0;
        end else if (req_pop) begin
            pkt_r[asm_cnt*axil_data_width_p +: axil_data_width_p] <= req_mem[req_rd_ptr];
            asm_cnt <= (asm_cnt == beat_last_lp) ? '0 : asm_cnt + 1'b1;
        end
    end

    // Outstanding reads and the sticky unsolicited-response flag; a new error
    // outranks a clear arriving in the same cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            outstanding_r <= '0;
            err_r         <= 1'b0;
        end else begin
            if (read_hs & ~credit_ret)      outstanding_r <= outstanding_r + 1'b1;
            else if (~read_hs & credit_ret) outstanding_r <= outstanding_r - 1'b1;
            if (rsp_hs && outstanding_r == '0) err_r <= 1'b1;
            else if (err_clear_i)              err_r <= 1'b0;
        end
    end

    assign outstanding_reads_o = outstanding_r;
    assign unsolicited_err_o   = err_r;

    // ---------------- response serialiser + beat buffer ----------------
    logic [fifo_width_p-1:0]      rsp_pkt_r;
    logic [beat_w_lp-1:0]         ser_cnt;
    logic [axil_data_width_p-1:0] rsp_mem [rsp_depth_lp];
    logic [rsp_ptr_w_lp-1:0]      rsp_wr_ptr, rsp_rd_ptr;
    logic [rsp_cnt_w_lp-1:0]      rsp_count;
    logic                         rsp_push, rsp_pop, ser_last;

    assign ser_last         = (ser_cnt == beat_last_lp);
    assign rsp_push         = (ser_state == SHIFT) & (rsp_count != rsp_full_lp);
    assign fifo_rsp_ready_o = (ser_state == IDLE) | (rsp_push & ser_last);
    assign rsp_hs           = fifo_rsp_v_i & fifo_rsp_ready_o;
    assign axil_rsp_v_o     = (rsp_count != '0);
    assign rsp_pop          = axil_rsp_v_o & axil_rsp_ready_i;
    assign axil_rsp_o       = rsp_mem[rsp_rd_ptr];
    assign rsp_occupancy_o  = rsp_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ser_state <= IDLE;
        else         ser_state <= ser_next;
    end

    always_comb begin
        ser_next = ser_state;
        case (ser_state)
            IDLE:    if (rsp_hs) ser_next = SHIFT;
            SHIFT:   if (rsp_push && ser_last && !rsp_hs) ser_next = IDLE;
            default: ser_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_pkt_r <= '0;
            ser_cnt   <= '0;
        end else begin
            if (rsp_hs)   rsp_pkt_r <= fifo_rsp_i;
            if (rsp_push) ser_cnt   <= ser_last ? '0 : ser_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsp_push) rsp_mem[rsp_wr_ptr] <= rsp_pkt_r[ser_cnt*axil_data_width_p +: axil_data_width_p];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_count  <= '0;
        end else begin
            if (rsp_push) rsp_wr_ptr <= (rsp_wr_ptr == rsp_ptr_last_lp) ? '0 : rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= (rsp_rd_ptr == rsp_ptr_last_lp) ? '0 : rsp_rd_ptr + 1'b1;
            if (rsp_push & ~rsp_pop)      rsp_count <= rsp_count + 1'b1;
            else if (~rsp_push & rsp_pop) rsp_count <= rsp_count - 1'b1;
        end
    end

endmodule
